// File: rtl/float16_divider.sv
// Iterative IEEE-754 binary16 divider (result = a / b).
// Restoring radix-2 mantissa division, one quotient bit per cycle, RNE rounding.
// Build option: define FP16_DIV_SUBNORM_EN to produce subnormal results;
// otherwise tiny results flush to signed zero with the underflow flag set.
module float16_divider #(
  parameter int FLOAT_LEN = 16,
  parameter int EXP_LEN   = 5,
  parameter int MANT_LEN  = 10,
  parameter int BIAS      = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_LEN-1:0] a,
  input  logic [FLOAT_LEN-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLOAT_LEN-1:0] result,
  output logic [3:0]           flags
);

  typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

  state_t                state;
  logic [FLOAT_LEN-1:0]  a_r, b_r;
  logic [10:0]           mb_r;
  logic signed [7:0]     exp_q;
  logic [11:0]           rem;
  logic [13:0]           q;
  logic [3:0]            cnt;

  // Leading-zero count of an 11-bit significand (11 when zero).
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd11;
    for (int unsigned i = 0; i < 11; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

  // Operand fields, classification and normalisation.
  logic [EXP_LEN-1:0]  a_exp, b_exp;
  logic [MANT_LEN-1:0] a_man, b_man;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [3:0]          lz_a, lz_b;
  logic [10:0]         ma_n, mb_n;
  logic signed [7:0]   ea_n, eb_n, exp_n;
  logic                sign_q;

  always_comb begin
    a_exp  = a_r[MANT_LEN +: EXP_LEN];
    b_exp  = b_r[MANT_LEN +: EXP_LEN];
    a_man  = a_r[MANT_LEN-1:0];
    b_man  = b_r[MANT_LEN-1:0];
    sign_q = a_r[FLOAT_LEN-1] ^ b_r[FLOAT_LEN-1];
    a_zero = (a_exp == '0) && (a_man == '0);
    b_zero = (b_exp == '0) && (b_man == '0);
    a_inf  = (a_exp == '1) && (a_man == '0);
    b_inf  = (b_exp == '1) && (b_man == '0);
    a_nan  = (a_exp == '1) && (a_man != '0);
    b_nan  = (b_exp == '1) && (b_man != '0);
    lz_a   = lzc11({1'b0, a_man});
    lz_b   = lzc11({1'b0, b_man});
    if (a_exp == '0) begin
      ma_n = {1'b0, a_man} << lz_a;
      ea_n = 8'sd1 - $signed({4'b0, lz_a});
    end else begin
      ma_n = {1'b1, a_man};
      ea_n = $signed({3'b0, a_exp});
    end
    if (b_exp == '0) begin
      mb_n = {1'b0, b_man} << lz_b;
      eb_n = 8'sd1 - $signed({4'b0, lz_b});
    end else begin
      mb_n = {1'b1, b_man};
      eb_n = $signed({3'b0, b_exp});
    end
    exp_n = ea_n - eb_n + $signed(8'(BIAS));
  end

  // Special-operand results, decided in the NORM cycle.
  logic                 spec_hit;
  logic [FLOAT_LEN-1:0] spec_res;
  logic [3:0]           spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = {sign_q, 5'h1F, 10'h200};
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      spec_res   = {sign_q, 5'h1F, 10'h000};
    end else if (b_zero) begin
      spec_res   = {sign_q, 5'h1F, 10'h000};
      spec_flags = 4'b0100;
    end else if (a_zero || b_inf) begin
      spec_res   = {sign_q, 15'h0000};
    end else begin
      spec_hit   = 1'b0;
    end
  end

  // One restoring-division step.
  logic        rem_ge;
  logic [11:0] rem_sub;

  always_comb begin
    rem_ge  = rem >= {1'b0, mb_r};
    rem_sub = rem_ge ? (rem - {1'b0, mb_r}) : rem;
  end

  // Normalise, round to nearest even, and resolve overflow/underflow.
  logic [9:0]           frac;
  logic                 g, r, s, up;
  logic [10:0]          frac_r;
  logic signed [7:0]    e1, e2;
  logic [FLOAT_LEN-1:0] rnd_res;
  logic [3:0]           rnd_flags;
`ifdef FP16_DIV_SUBNORM_EN
  logic [13:0]          sig14, shifted;
  logic signed [7:0]    sh8;
  logic [3:0]           sh;
  logic                 lost, sg, sr, ss, sup;
  logic [10:0]          sub_frac, sub_rnd;
`endif

  always_comb begin
    if (q[13]) begin
      frac = q[12:3];
      g    = q[2];
      r    = q[1];
      s    = q[0] | (rem != '0);
      e1   = exp_q;
    end else begin
      frac = q[11:2];
      g    = q[1];
      r    = q[0];
      s    = (rem != '0);
      e1   = exp_q - 8'sd1;
    end
    up        = g & (r | s | frac[0]);
    // A carry out of the fraction leaves frac_r[9:0] zero, as required.
    frac_r    = {1'b0, frac} + 11'(up);
    e2        = e1 + $signed({7'b0, frac_r[10]});
    rnd_res   = {sign_q, e2[4:0], frac_r[9:0]};
    rnd_flags = '0;
`ifdef FP16_DIV_SUBNORM_EN
    // Normalised significand always carries a hidden 1 here.
    sig14    = {1'b1, frac, g, r, s};
    sh8      = 8'sd1 - e1;
    sh       = (sh8 > 8'sd14) ? 4'd14 : sh8[3:0];
    shifted  = sig14 >> sh;
    lost     = |(sig14 & ~(14'h3FFF << sh));
    sub_frac = shifted[13:3];
    sg       = shifted[2];
    sr       = shifted[1];
    ss       = shifted[0] | lost;
    sup      = sg & (sr | ss | sub_frac[0]);
    sub_rnd  = sub_frac + 11'(sup);
`endif
    if (e2 >= 8'sd31) begin
      rnd_res   = {sign_q, 5'h1F, 10'h000};
      rnd_flags = 4'b0010;
    end else if (e2 <= 8'sd0) begin
`ifdef FP16_DIV_SUBNORM_EN
      // Hidden bit reaching bit 10 after rounding becomes exponent field 1.
      rnd_res   = {sign_q, 4'b0000, sub_rnd};
      rnd_flags = {3'b000, sg | sr | ss};
`else
      rnd_res   = {sign_q, 15'h0000};
      rnd_flags = 4'b0001;
`endif
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      mb_r      <= '0;
      exp_q     <= '0;
      rem       <= '0;
      q         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          if (spec_hit) begin
            result    <= spec_res;
            flags     <= spec_flags;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rem   <= {1'b0, ma_n};
            mb_r  <= mb_n;
            exp_q <= exp_n;
            q     <= '0;
            cnt   <= 4'd13;
            state <= DIV;
          end
        end
        DIV: begin
          q   <= {q[12:0], rem_ge};
          rem <= rem_sub << 1;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= ROUND;
        end
        ROUND: begin
          result    <= rnd_res;
          flags     <= rnd_flags;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float16_divider.sv
// Scoreboard bench for float16_divider: directed operands with hand-computed
// quotients; a negedge monitor pops expectations on every output handshake.
module tb_float16_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  logic [19:0] sb_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  float16_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: compare each accepted output against the oldest expectation.
  initial begin
    logic [19:0] exp_v;
    string       nm;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: actual %h/%h required none", result, flags);
        end else begin
          exp_v = sb_q.pop_front();
          nm    = name_q.pop_front();
          check({nm, "_result_flags"}, 32'({result, flags}), 32'(exp_v));
        end
      end
    end
  end

  // Called at posedge+2; returns at E+2 where E is the accept edge.
  task automatic start_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] er, input logic [3:0] ef, input bit push);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, "_ready"}, 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    if (push) begin
      sb_q.push_back({er, ef});
      name_q.push_back(name);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Measures edges from accept to out_valid and checks in_ready stays low.
  task automatic wait_out(input string name, input int exp_lat);
    int lat  = 0;
    bit busy = 1'b1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) busy = 1'b0;
      @(posedge clk); #2;
      lat++;
    end
    if (in_ready !== 1'b0) busy = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy"}, 32'(busy), 32'(1));
  endtask

  task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic [3:0] ef, input int lat);
    start_op(name, av, bv, er, ef, 1'b1);
    wait_out(name, lat);
    @(posedge clk); #2;
    check({name, "_idle"}, 32'({out_valid, in_ready}), 32'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;
    bit quiet;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", 32'({in_ready, out_valid, result, flags}), 32'({1'b1, 1'b0, 16'h0000, 4'h0}));
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Finite operands: 16-cycle latency.
    run_op("div_3_by_1p5",  16'h4200, 16'h3E00, 16'h4000, 4'b0000, 16);
    run_op("div_1_by_3",    16'h3C00, 16'h4200, 16'h3555, 4'b0000, 16);
    run_op("div_m1_by_3",   16'hBC00, 16'h4200, 16'hB555, 4'b0000, 16);
    run_op("div_5_by_7",    16'h4500, 16'h4700, 16'h39B7, 4'b0000, 16);
    run_op("div_sub_sub",   16'h0001, 16'h0001, 16'h3C00, 4'b0000, 16);
    run_op("overflow",      16'h7BFF, 16'h3800, 16'h7C00, 4'b0010, 16);
`ifdef FP16_DIV_SUBNORM_EN
    run_op("underflow",     16'h0400, 16'h4000, 16'h0200, 4'b0000, 16);
`else
    run_op("underflow",     16'h0400, 16'h4000, 16'h0000, 4'b0001, 16);
`endif

    // Special operands: 1-cycle latency.
    run_op("one_by_zero",   16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 1);
    run_op("neg_by_zero",   16'hBC00, 16'h0000, 16'hFC00, 4'b0100, 1);
    run_op("zero_by_zero",  16'h0000, 16'h0000, 16'h7E00, 4'b1000, 1);
    run_op("inf_by_inf",    16'h7C00, 16'h7C00, 16'h7E00, 4'b1000, 1);
    run_op("nan_by_one",    16'h7C01, 16'h3C00, 16'h7E00, 4'b1000, 1);
    run_op("inf_by_one",    16'h7C00, 16'h3C00, 16'h7C00, 4'b0000, 1);
    run_op("two_by_inf",    16'h4000, 16'h7C00, 16'h0000, 4'b0000, 1);

    // Backpressure: result held, new operands refused while in DONE.
    out_ready = 1'b0;
    start_op("backpressure", 16'h4200, 16'h3E00, 16'h4000, 4'b0000, 1'b1);
    wait_out("backpressure", 16);
    in_valid = 1'b1;
    a        = 16'h3C00;
    b        = 16'h0000;
    stable   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 16'h4000, 4'h0}) stable = 1'b0;
    end
    check("backpressure_stable", 32'(stable), 32'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("backpressure_release", 32'({out_valid, in_ready}), 32'(2'b01));
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk); #2;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    check("no_extra_accept", 32'(quiet), 32'(1));

    // Reset in the middle of DIV aborts the operation.
    start_op("abort", 16'h4200, 16'h3E00, 16'h0000, 4'b0000, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    check("abort_busy", 32'({out_valid, in_ready}), 32'(2'b00));
    rst_n = 1'b0;
    #1;
    check("abort_reset_outputs", 32'({in_ready, out_valid, result, flags}), 32'({1'b1, 1'b0, 16'h0000, 4'h0}));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    run_op("after_reset", 16'h3C00, 16'h4200, 16'h3555, 4'b0000, 16);

    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float16_divider.md
Name: float16_divider

Overview:
- Iterative IEEE-754 binary16 divider (result = a / b) for the activation accelerator datapath. It is the inverse-operation companion to the combinational float16 multiplier.
- Uses a restoring radix-2 mantissa divider, one quotient bit per cycle, with Round-to-Nearest-Even (RNE).
- Single operand pair in flight, valid/ready handshake on both sides.
- Used for normalisation and reciprocal terms (softmax, layer-norm).

Parameters:
FLOAT_LEN, 16, total operand width
EXP_LEN, 5, exponent width
MANT_LEN, 10, stored mantissa width
BIAS, 15, exponent bias

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b valid
in_ready  output  1  divider idle, can accept
a  input  16  dividend
b  input  16  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  16  quotient, binary16
flags  output  4  {invalid, div_by_zero, overflow, underflow}, valid with out_valid

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=16'h0000, flags=4'b0000, all internal registers cleared.
- Reset mid-operation aborts the divide immediately. No output is produced for the aborted operands.
- States: IDLE, NORM, DIV, ROUND, DONE.
- in_ready is high only in IDLE. Operands are accepted on an edge with in_valid && in_ready. Call that edge E.
- IDLE -> NORM on accept; a and b are registered.
- NORM (edge E+1):
  - Classify both operands.
  - Special cases go straight to DONE, so out_valid is high from E+1:
    - either operand NaN, 0/0, or inf/inf -> {sign,5'h1F,10'h200}, invalid=1.
    - inf/finite -> signed inf.
    - finite-nonzero/0 -> signed inf, div_by_zero=1.
    - 0/nonzero or finite/inf -> signed zero.
  - sign = a[15]^b[15] in every case.
  - Otherwise normalise subnormal operands: shift the mantissa left by its leading-zero count lz; effective exponent = 1-lz. Normal operands use exp and the hidden 1.
  - Compute exp_q = ea - eb + BIAS in signed 8 bits.
  - Load rem = {1'b0, ma} (12 bits), load the 4-bit iteration counter with 13, then go to DIV.
- DIV, edges E+2..E+15, 14 iterations:
  - If rem >= mb: q bit=1, rem -= mb; else q bit=0.
  - Then rem <<= 1; counter decrements.
  - At counter==0 go to ROUND.
  - Result q[13:0] = floor(ma*2^13/mb).
- ROUND (edge E+16, then DONE):
  - If q[13]=1: mantissa = q[13:3], guard = q[2], round = q[1], sticky = q[0] | (rem!=0).
  - If q[13]=0: mantissa = q[12:2], guard = q[1], round = q[0], sticky = (rem!=0), and exp_q -= 1.
  - RNE round-up = G&(R|S|L), where L = mantissa lsb.
  - Carry out of the 11-bit mantissa: exp_q+1, mantissa=0.
  - exp_q >= 31 -> signed inf, overflow=1.
  - exp_q <= 0 -> see Optional Feature.
- DONE:
  - out_valid=1; result and flags stay stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0 on the next edge, state -> IDLE.
  - in_valid is ignored outside IDLE; there is no back-to-back accept in DONE.
- Latency: 1 cycle for specials, 16 cycles for finite nonzero operands. Throughput is one operation per latency+2 cycles minimum.

Optional Feature:
- Macro: FP16_DIV_SUBNORM_EN.
- Defined: results with exp_q <= 0 are denormalised within the ROUND cycle.
  - Right-shift the 14-bit significand+GRS by 1-exp_q, capped at 14.
  - Shifted-out bits OR into sticky, then apply RNE.
  - Exponent field = 0, or 1 if rounding carries into the hidden bit.
  - underflow=1 only if the result is inexact.
- Undefined: exp_q <= 0 flushes to signed zero (FTZ) with underflow=1.

Test Plan:
- a=16'h4200 (3.0), b=16'h3E00 (1.5) -> result 16'h4000, flags 0, out_valid exactly 16 cycles after accept, in_ready=0 throughout.
- a=16'h3C00, b=16'h4200 (1/3) -> result 16'h3555, flags 0. Repeat with a=16'hBC00 -> 16'hB555.
- Specials:
  - 16'h3C00/16'h0000 -> 16'h7C00 with div_by_zero.
  - 16'h0000/16'h0000 -> 16'h7E00 with invalid.
  - 16'h7C00/16'h7C00 -> 16'h7E00 with invalid.
  - 16'h4000/16'h7C00 -> 16'h0000.
  - All with 1-cycle latency.
- Overflow: 16'h7BFF/16'h3800 -> 16'h7C00, overflow=1.
- Underflow: 16'h0400/16'h4000 -> 16'h0200 with FP16_DIV_SUBNORM_EN, flags 0; without the macro -> 16'h0000, underflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after out_valid: result and flags stay stable, in_ready=0, a new in_valid is not accepted.
  - Assert rst_n=0 mid-DIV (cycle E+8): all outputs return to reset values asynchronously.
  - Next operation after reset completes correctly.
